fft_twiddle_seq: RTL
====================

// Module: fft_twiddle_seq
// PURPOSE
//  Parametrised N-point FFT twiddle generator; successor to the fixed 4-point real/imag twiddle LUTs.
//  On Start, sweeps k (outer) and n (inner) over 0..N-1 and streams W_N^(k*n) = exp(-j*2*pi*k*n/N).
//  Each coefficient is tagged with its k,n indices; valid/ready backpressure feeds the DFT/FFT datapath.
// PARAMETERS
//  N_LOG2  3   log2 of transform size N; supported range 2..6
//  WIDTH   17  signed two's-complement coefficient width; unity = 2^(WIDTH-2), so 1.0 is exact
// PORTS
//  Clk         in   1        single clock; all state updates on the rising edge
//  Reset       in   1        asynchronous, active-low reset
//  Start       in   1        sweep request; sampled only in IDLE
//  busy        out  1        high from accepted Start until Done
//  done        out  1        one-cycle pulse when the last coefficient is accepted
//  out_valid   out  1        coefficient/index outputs valid
//  out_ready   in   1        consumer accepts when out_valid && out_ready
//  out_k       out  N_LOG2   k index of the current coefficient
//  out_n       out  N_LOG2   n index of the current coefficient
//  coeff_real  out  WIDTH    round(cos(2*pi*m/N) * 2^(WIDTH-2)), m = (k*n) mod N
//  coeff_imag  out  WIDTH    round(-sin(2*pi*m/N) * 2^(WIDTH-2))
// BEHAVIOUR
//  - Reset (Reset=0, asynchronous): FSM=IDLE, counters=0; busy, done and out_valid are 0;
//    out_k, out_n, coeff_real and coeff_imag are 0. Reset mid-sweep aborts with no done pulse.
//  - FSM: IDLE -> RUN on Start. RUN -> DRAIN after the (N-1,N-1) index is issued.
//    DRAIN -> IDLE when the last coefficient is accepted; done=1 for that one cycle.
//  - Start while busy is ignored. Start in the same cycle as done is ignored; Start must be
//    reasserted in IDLE.
//  - Pipeline S1: registers m = (k*n) mod N, i.e. the low N_LOG2 bits of the product, plus k,n and a valid bit.
//  - Pipeline S2: registers the ROM lookup into the coeff_* outputs with out_k/out_n/out_valid.
//  - Latency: Start accepted at edge t gives out_valid=1 after edge t+2. With out_ready held high,
//    one coefficient per cycle and N*N consecutive valid cycles.
//  - Stall: when out_valid && !out_ready, S1, S2 and the k/n counters all hold. Outputs stay
//    stable until accepted; no coefficient is dropped or duplicated.
//  - Counters: n wraps N-1 -> 0 and increments k; k=N-1, n=N-1 is the final index.
//  - ROM contents are computed at elaboration by constant functions (Verilog-2005 real $cos/$sin).
//    Values round half away from zero and are saturated to [-2^(WIDTH-2), 2^(WIDTH-2)].
//  - Exact values: m=0 -> (+unity, 0); m=N/4 -> (0, -unity); m=N/2 -> (-unity, 0);
//    m=3N/4 -> (0, +unity).
//  - busy=1 from the edge accepting Start through the edge at which done is asserted.
// CONFIGURATION
//  TWIDDLE_QUARTER_WAVE_EN defined:
//    - ROM holds only N/4+1 cosine entries (m = 0..N/4).
//    - Sine and cosine for any m are derived by octant mirroring and negation in S2.
//  Not defined: full N-entry real and imag ROMs, indexed directly by m.
//  Output values, latency and handshake are identical in both builds.
// TESTING
//  1. N_LOG2=3; Reset low mid-sweep after 10 accepted coefficients -> all outputs 0 at once.
//     Then Start -> first coefficient is k=0,n=0 again.
//  2. N_LOG2=3, out_ready=1, Start pulse at edge t -> out_valid after t+2; 64 consecutive valid cycles.
//     done pulses with k=7,n=7; busy drops the cycle after done.
//  3. N_LOG2=3, k=1,n=1 (m=1) -> coeff_real=17'h05A82, coeff_imag=17'h1A57E.
//     k=2,n=1 (m=2) -> real=0, imag=17'h18000. k=2,n=2 (m=4) -> real=17'h18000, imag=0.
//  4. N_LOG2=2; k=1,n=3 (m=3) -> real=0, imag=17'h08000.
//     k=3,n=3 (m=1) -> real=0, imag=17'h18000. 16 coefficients, then done.
//  5. Backpressure: out_ready=0 for 5 cycles at k=3,n=5 -> outputs frozen.
//     Release -> next is k=3,n=6; no gaps or duplicates; total still 64.
//  6. Start asserted while busy, and again in the done cycle -> ignored.
//     Exactly one sweep occurs; rerun with TWIDDLE_QUARTER_WAVE_EN -> bit-identical trace.

Source files
------------

// File: rtl/fft_twiddle_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : fft_twiddle_seq_if
// Brief   : Start/status and valid/ready coefficient stream of the twiddle
//           sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface fft_twiddle_seq_if #(
  parameter int N_LOG2 = 3,
  parameter int WIDTH  = 17
);
  logic              Start;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [N_LOG2-1:0] out_k;
  logic [N_LOG2-1:0] out_n;
  logic [WIDTH-1:0]  coeff_real;
  logic [WIDTH-1:0]  coeff_imag;

  modport master (
    input  Start, out_ready,
    output busy, done, out_valid, out_k, out_n, coeff_real, coeff_imag
  );

  modport slave (
    output Start, out_ready,
    input  busy, done, out_valid, out_k, out_n, coeff_real, coeff_imag
  );
endinterface
`default_nettype wire

// File: rtl/fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module  : fft_twiddle_seq
// Brief   : Streams W_N^(k*n) for k,n = 0..N-1 through a two-stage pipeline.
//           Define TWIDDLE_QUARTER_WAVE_EN for a quarter-wave cosine ROM.
// Revision: 1.0 - initial release
// ============================================================================
module fft_twiddle_seq #(
  parameter int N_LOG2 = 3,
  parameter int WIDTH  = 17
) (
  input  wire logic           Clk,
  input  wire logic           Reset,
  fft_twiddle_seq_if.master   bus
);

  localparam int c_n = 1 << N_LOG2;
  localparam int c_q = c_n / 4;
  localparam logic [N_LOG2-1:0] c_last = '1;
  localparam logic signed [WIDTH-1:0] c_unity = WIDTH'(1 << (WIDTH-2));
  localparam real c_unity_r = 1.0 * (1 << (WIDTH-2));
  localparam real c_pi = 3.14159265358979323846;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  // First-quadrant cosine; the end points are forced so 1.0 and 0 are exact.
  function automatic logic signed [WIDTH-1:0] f_cos_q(input int r);
    real x;
    real s;
    int  v;
    if (r == 0) return c_unity;
    if (r == c_q) return '0;
    x = $cos(2.0 * c_pi * r / c_n) * c_unity_r;
    s = (x >= 0.0) ? $floor(x + 0.5) : -$floor(-x + 0.5);
    if (s > c_unity_r) s = c_unity_r;
    if (s < -c_unity_r) s = -c_unity_r;
    v = $rtoi(s);
    return v[WIDTH-1:0];
  endfunction

  logic [1:0]        r_state;
  logic [N_LOG2-1:0] r_k;
  logic [N_LOG2-1:0] r_n;
  logic              r_s1_valid;
  logic [N_LOG2-1:0] r_s1_k;
  logic [N_LOG2-1:0] r_s1_n;
  logic [N_LOG2-1:0] r_s1_m;
  logic              r_out_valid;
  logic [N_LOG2-1:0] r_out_k;
  logic [N_LOG2-1:0] r_out_n;
  logic [WIDTH-1:0]  r_re;
  logic [WIDTH-1:0]  r_im;

  logic              w_stall;
  logic              w_issue;
  logic              w_last_idx;
  logic              w_done;
  logic [N_LOG2-1:0] w_m;
  logic signed [WIDTH-1:0] w_re;
  logic signed [WIDTH-1:0] w_im;

  assign w_stall    = r_out_valid && !bus.out_ready;
  assign w_issue    = (r_state == c_st_run) && !w_stall;
  assign w_last_idx = (r_k == c_last) && (r_n == c_last);
  assign w_done     = (r_state == c_st_drain) && r_out_valid && bus.out_ready &&
                      (r_out_k == c_last) && (r_out_n == c_last);
  // Keeping the product at N_LOG2 bits is exactly the mod-N reduction.
  assign w_m        = r_k * r_n;

`ifdef TWIDDLE_QUARTER_WAVE_EN
  localparam int c_qw = (c_q + 1 > 1) ? $clog2(c_q + 1) : 1;
  localparam logic [N_LOG2-1:0] c_qmask = N_LOG2'(c_q - 1);

  logic signed [WIDTH-1:0] w_rom_cos [c_q+1];
  logic [c_qw-1:0]         w_ia;
  logic [c_qw-1:0]         w_ib;
  logic [1:0]              w_quad;
  logic signed [WIDTH-1:0] w_ca;
  logic signed [WIDTH-1:0] w_cb;

  for (genvar gi = 0; gi <= c_q; gi++) begin : g_rom
    localparam logic signed [WIDTH-1:0] c_cos = f_cos_q(gi);
    assign w_rom_cos[gi] = c_cos;
  end

  assign w_quad = r_s1_m[N_LOG2-1 -: 2];
  assign w_ia   = c_qw'(r_s1_m & c_qmask);
  assign w_ib   = c_qw'(c_q) - w_ia;
  assign w_ca   = w_rom_cos[w_ia];
  assign w_cb   = w_rom_cos[w_ib];

  // cos/-sin of quadrant q from the first-quadrant table, mirrored about pi/4.
  always_comb begin
    w_re = w_ca;
    w_im = -w_cb;
    case (w_quad)
      2'd0: begin w_re = w_ca;  w_im = -w_cb; end
      2'd1: begin w_re = -w_cb; w_im = -w_ca; end
      2'd2: begin w_re = -w_ca; w_im = w_cb;  end
      default: begin w_re = w_cb; w_im = w_ca; end
    endcase
  end
`else
  function automatic logic signed [WIDTH-1:0] f_re(input int m);
    case (m / c_q)
      0:       return f_cos_q(m % c_q);
      1:       return -f_cos_q(c_q - (m % c_q));
      2:       return -f_cos_q(m % c_q);
      default: return f_cos_q(c_q - (m % c_q));
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] f_im(input int m);
    case (m / c_q)
      0:       return -f_cos_q(c_q - (m % c_q));
      1:       return -f_cos_q(m % c_q);
      2:       return f_cos_q(c_q - (m % c_q));
      default: return f_cos_q(m % c_q);
    endcase
  endfunction

  logic signed [WIDTH-1:0] w_rom_re [c_n];
  logic signed [WIDTH-1:0] w_rom_im [c_n];

  for (genvar gi = 0; gi < c_n; gi++) begin : g_rom
    localparam logic signed [WIDTH-1:0] c_re = f_re(gi);
    localparam logic signed [WIDTH-1:0] c_im = f_im(gi);
    assign w_rom_re[gi] = c_re;
    assign w_rom_im[gi] = c_im;
  end

  assign w_re = w_rom_re[r_s1_m];
  assign w_im = w_rom_im[r_s1_m];
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= c_st_idle;
      r_k         <= '0;
      r_n         <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_k      <= '0;
      r_s1_n      <= '0;
      r_s1_m      <= '0;
      r_out_valid <= 1'b0;
      r_out_k     <= '0;
      r_out_n     <= '0;
      r_re        <= '0;
      r_im        <= '0;
    end else begin
      case (r_state)
        c_st_idle:  if (bus.Start) r_state <= c_st_run;
        c_st_run:   if (w_issue && w_last_idx) r_state <= c_st_drain;
        c_st_drain: if (w_done) r_state <= c_st_idle;
        default:    r_state <= c_st_idle;
      endcase

      // Counters wrap back to (0,0) after the final index, ready for the next sweep.
      if (w_issue) begin
        r_n <= r_n + 1'b1;
        if (r_n == c_last) r_k <= r_k + 1'b1;
      end

      if (!w_stall) begin
        r_s1_valid  <= w_issue;
        r_s1_k      <= r_k;
        r_s1_n      <= r_n;
        r_s1_m      <= w_m;
        r_out_valid <= r_s1_valid;
        r_out_k     <= r_s1_k;
        r_out_n     <= r_s1_n;
        r_re        <= w_re;
        r_im        <= w_im;
      end
    end
  end

  assign bus.busy       = (r_state != c_st_idle);
  assign bus.done       = w_done;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_k      = r_out_k;
  assign bus.out_n      = r_out_n;
  assign bus.coeff_real = r_re;
  assign bus.coeff_imag = r_im;

endmodule
`default_nettype wire
